mq_port_controller: RTL and testbench
=====================================

MQ_PORT_CONTROLLER -- requirements
Module: mq_port_controller

Interface
REQ-001 Parameter DATA_W, default 64: datapath width in bits, a multiple of 8; KEEP_W = DATA_W/8.
REQ-002 Parameter NUM_Q, default 4: number of egress queues, 2..8.
REQ-003 Parameter Q_DEPTH, default 64: beats per queue, a power of two of at least 4.
REQ-004 Parameter QW = $clog2(NUM_Q), derived: queue index width.
REQ-005 Port clk, input, 1: clock; all logic on the rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port enable, input, 1: block enable.
REQ-008 Ports rx_valid/rx_last (input, 1), rx_data (input, DATA_W), rx_keep (input, KEEP_W), rx_qid (input, QW), rx_ready (output, 1): ingress stream; rx_qid is sampled on the first beat of a packet.
REQ-009 Ports tx_valid/tx_last (output, 1), tx_data (output, DATA_W), tx_keep (output, KEEP_W), tx_qid (output, QW), tx_ready (input, 1): egress stream.
REQ-010 Port sched_mode, input, 1: egress arbitration, 0 = strict priority, 1 = round-robin.
REQ-011 Ports q_full and q_empty, output, NUM_Q each: per-queue status.
REQ-012 Ports rx_pkt_cnt, tx_pkt_cnt, drop_pkt_cnt, rx_byte_cnt and tx_byte_cnt, output, 32 each: statistics.

Function
REQ-013 rx_ready SHALL equal enable; ingress never back-pressures, and overflow is resolved by dropping.
REQ-014 Storage SHALL be store-and-forward per queue; a packet is committed only when its last beat is written.
REQ-015 If the target queue has no free slot on any beat of a packet, the block SHALL discard that beat and all remaining beats of the packet, rewind the write pointer to the packet start, and increment drop_pkt_cnt on the last beat.
REQ-016 An rx_qid value of NUM_Q or greater SHALL cause the whole packet to be dropped and counted in drop_pkt_cnt.
REQ-017 The egress FSM SHALL have states IDLE, ARB and SEND: IDLE moves to ARB when any queue holds a committed packet; ARB selects a queue and moves to SEND in one cycle; SEND moves to IDLE after the beat with tx_last is accepted.
REQ-018 In strict-priority mode, ARB SHALL select the lowest-indexed queue that holds a committed packet.
REQ-019 In round-robin mode, ARB SHALL select the first eligible queue after the last-served queue, wrapping from NUM_Q-1 to 0.
REQ-020 A sched_mode change SHALL take effect only at the next ARB.
REQ-021 Once in SEND, the FSM SHALL stay locked to the selected queue until the last beat is accepted, and tx_qid SHALL remain constant throughout.
REQ-022 While tx_valid=1 and tx_ready=0, tx_valid, tx_data, tx_keep, tx_last and tx_qid SHALL hold stable.
REQ-023 Latency SHALL be exactly 2 cycles from acceptance of the rx_last beat to tx_valid, given an idle egress path and an otherwise empty block.
REQ-024 A simultaneous write and read on the same queue SHALL both proceed.
REQ-025 A simultaneous commit and drain on the same queue SHALL leave the committed-packet count for that queue unchanged.
REQ-026 q_full[i] SHALL be 1 when queue i holds Q_DEPTH beats, and q_empty[i] SHALL be 1 when it holds 0 beats.
REQ-027 Pointers SHALL wrap modulo Q_DEPTH.
REQ-028 All counters SHALL wrap modulo 2^32.
REQ-029 Byte counters SHALL add the popcount of keep on every accepted, non-dropped beat.
REQ-030 When enable=0, ingress SHALL pause; a partial packet is retained and resumes when enable returns.
REQ-031 When enable=0, egress SHALL finish any packet in SEND and then not leave IDLE.

Reset
REQ-032 On rst_n low, all pointers, per-queue packet counts, the round-robin pointer and all statistics SHALL clear to 0, and the FSM SHALL enter IDLE.
REQ-033 Reset output values SHALL be: tx_valid=0, tx_last=0, tx_qid=0, q_empty all 1, q_full all 0, rx_ready=0. tx_data and tx_keep are don't-care during reset.
REQ-034 Reset SHALL discard partial and committed packets; no stale beat is emitted after reset.

Configuration
REQ-035 Macro MQPC_BYTE_STATS_EN: when defined, rx_byte_cnt and tx_byte_cnt SHALL be implemented as REQ-029; when undefined, both outputs SHALL be tied to 0 and the popcount logic omitted. Packet counters exist in both builds.

Verification
REQ-036 Single 3-beat packet to queue 2, keep=FF each beat: tx emits 3 beats with tx_qid=2, tx_valid 2 cycles after rx_last; rx_pkt_cnt=1, tx_pkt_cnt=1, byte counts 24.
REQ-037 Overflow: tx_ready=0, then 17 single-beat packets to queue 0 with Q_DEPTH=16: q_full[0]=1 and drop_pkt_cnt=1; after release, exactly 16 packets emerge.
REQ-038 Mid-packet overflow: 20-beat packet into an empty 16-deep queue: drop_pkt_cnt=1, q_empty=1, and no tx_valid.
REQ-039 Strict priority vs round-robin: queues 0 and 3 each hold 2 packets: strict order is 0,0,3,3; round-robin order is 0,3,0,3.
REQ-040 Backpressure and reset: toggle tx_ready every cycle and check that outputs hold stable; assert rst_n mid-SEND and check that tx_valid=0 immediately and all counters read 0.

Source files
------------

// File: rtl/mq_port_controller.sv
// mq_port_controller
//
// Multi-queue store-and-forward port controller. Ingress packets are steered
// into one of NUM_Q egress queues by rx_qid, which is taken from the first
// beat of each packet. A packet only becomes visible to egress once its last
// beat has been written. A packet that does not fit is discarded whole: the
// queue's write pointer is rewound to the packet start. Egress picks a queue
// holding a complete packet, either by strict priority (lowest index first)
// or round-robin, and streams that packet out without interleaving.
//
// Optional feature: define MQPC_BYTE_STATS_EN to build the byte counters.
// Without it, rx_byte_cnt and tx_byte_cnt read 0 and no popcount logic exists.
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid and ready are both 1. The source holds valid and all payload fields
// stable until that edge. Ingress never back-pressures (rx_ready == enable
// out of reset), so overflow is resolved by dropping whole packets.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   enable            : block enable; gates ingress and the start of egress
//   rx_*              : ingress stream (valid/ready/data/keep/last/qid)
//   tx_*              : egress stream (valid/ready/data/keep/last/qid)
//   sched_mode        : 0 = strict priority, 1 = round-robin (sampled in ARB)
//   q_full, q_empty   : per-queue occupancy status
//   rx/tx/drop_pkt_cnt: packet statistics, wrap modulo 2^32
//   rx/tx_byte_cnt    : byte statistics (MQPC_BYTE_STATS_EN only, else 0)
//   dbg_state         : egress FSM state, 0 = IDLE, 1 = ARB, 2 = SEND
module mq_port_controller #(
  parameter int DATA_W  = 64,
  parameter int NUM_Q   = 4,
  parameter int Q_DEPTH = 64,
  // Derived widths; leave at their defaults.
  parameter int KEEP_W  = DATA_W / 8,
  parameter int QW      = $clog2(NUM_Q)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rx_valid,
  input  logic              rx_last,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [KEEP_W-1:0] rx_keep,
  input  logic [QW-1:0]     rx_qid,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic              tx_last,
  output logic [DATA_W-1:0] tx_data,
  output logic [KEEP_W-1:0] tx_keep,
  output logic [QW-1:0]     tx_qid,
  input  logic              tx_ready,
  input  logic              sched_mode,
  output logic [NUM_Q-1:0]  q_full,
  output logic [NUM_Q-1:0]  q_empty,
  output logic [31:0]       rx_pkt_cnt,
  output logic [31:0]       tx_pkt_cnt,
  output logic [31:0]       drop_pkt_cnt,
  output logic [31:0]       rx_byte_cnt,
  output logic [31:0]       tx_byte_cnt,
  output logic [1:0]        dbg_state
);

  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = PW + 1;               // occupancy counts reach Q_DEPTH
  localparam int MW = 1 + KEEP_W + DATA_W;  // stored word: {last, keep, data}

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Packet storage, one ring per queue. Not reset: occupancy tracking alone
  // decides which entries are meaningful.
  logic [MW-1:0] mem [NUM_Q][Q_DEPTH];

  // Per-queue bookkeeping
  logic [PW-1:0] wr_ptr_q  [NUM_Q], wr_ptr_d  [NUM_Q];
  logic [PW-1:0] start_q   [NUM_Q], start_d   [NUM_Q];  // start of open packet
  logic [PW-1:0] rd_ptr_q  [NUM_Q], rd_ptr_d  [NUM_Q];
  logic [CW-1:0] cnt_q     [NUM_Q], cnt_d     [NUM_Q];  // beats held
  logic [CW-1:0] pkt_cnt_q [NUM_Q], pkt_cnt_d [NUM_Q];  // committed packets

  // Ingress packet tracking
  logic          in_pkt_q, in_pkt_d;        // a packet is partly received
  logic [QW-1:0] cur_qid_q, cur_qid_d;
  logic          drop_q, drop_d;            // discarding rest of packet
  logic [CW-1:0] pkt_beats_q, pkt_beats_d;  // beats written for open packet

  // Egress FSM
  state_t        state_q, state_d;
  logic [QW-1:0] sel_q, sel_d;
  logic [QW-1:0] rr_q, rr_d;                // last-served queue

  logic [31:0] rx_pkt_q, rx_pkt_d, tx_pkt_q, tx_pkt_d, drop_cnt_q, drop_cnt_d;

  logic            acc, wr_en, commit, rewind, drop_evt;
  logic [QW-1:0]   wq;
  logic [(1<<QW)-1:0] qid_ok_mask;
  logic            rd_fire, rd_last, pkt_any, found;
  logic [QW-1:0]   pick, rr_cand;
  logic [MW-1:0]   rd_word;

  assign rx_ready = enable && rst_n;
  assign acc      = rx_valid && rx_ready;

  // Which qid codes name a real queue (matters when NUM_Q is not 2^QW).
  always_comb begin
    qid_ok_mask = '0;
    for (int i = 0; i < (1 << QW); i++) qid_ok_mask[i] = (i < NUM_Q);
  end

  // ---------------- ingress ----------------
  always_comb begin
    in_pkt_d    = in_pkt_q;
    cur_qid_d   = cur_qid_q;
    drop_d      = drop_q;
    pkt_beats_d = pkt_beats_q;
    wr_en       = 1'b0;
    commit      = 1'b0;
    rewind      = 1'b0;
    drop_evt    = 1'b0;
    wq          = in_pkt_q ? cur_qid_q : rx_qid;
    if (acc) begin
      in_pkt_d    = !rx_last;
      cur_qid_d   = wq;
      pkt_beats_d = '0;
      if (in_pkt_q ? drop_q : !qid_ok_mask[rx_qid]) begin
        drop_d   = !rx_last;
        drop_evt = rx_last;
      end else if (cnt_q[wq] == CW'(Q_DEPTH)) begin
        // No room: abandon what was written of this packet.
        rewind   = 1'b1;
        drop_d   = !rx_last;
        drop_evt = rx_last;
      end else begin
        wr_en  = 1'b1;
        commit = rx_last;
        drop_d = 1'b0;
        if (!rx_last) pkt_beats_d = pkt_beats_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wq][wr_ptr_q[wq]] <= {rx_last, rx_keep, rx_data};
  end

  // ---------------- egress FSM ----------------
  assign rd_word  = mem[sel_q][rd_ptr_q[sel_q]];
  assign rd_last  = rd_word[MW-1];
  assign tx_data  = rd_word[DATA_W-1:0];
  assign tx_keep  = rd_word[DATA_W +: KEEP_W];
  assign tx_qid   = sel_q;
  assign tx_last  = tx_valid && rd_last;
  assign dbg_state = state_q;

  // Queue choice for the coming ARB cycle.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    rr_cand = '0;
    pkt_any = 1'b0;
    for (int i = 0; i < NUM_Q; i++) pkt_any = pkt_any || (pkt_cnt_q[i] != '0);
    if (!sched_mode) begin
      for (int i = 0; i < NUM_Q; i++) begin
        if (!found && pkt_cnt_q[i] != '0) begin
          found = 1'b1;
          pick  = QW'(i);
        end
      end
    end else begin
      // Scan starts just after the last-served queue and ends on it.
      for (int k = 1; k <= NUM_Q; k++) begin
        rr_cand = QW'((int'(rr_q) + k) % NUM_Q);
        if (!found && pkt_cnt_q[rr_cand] != '0) begin
          found = 1'b1;
          pick  = rr_cand;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    tx_valid = 1'b0;
    rd_fire  = 1'b0;
    unique case (state_q)
      // A commit in flight counts so that ARB lands in the cycle after it.
      ST_IDLE: if (enable && (pkt_any || commit)) state_d = ST_ARB;
      ST_ARB: begin
        if (!enable || !found) begin
          state_d = ST_IDLE;
        end else begin
          sel_d   = pick;
          rr_d    = pick;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // Whole packet is already stored, so valid never drops mid-packet.
        tx_valid = 1'b1;
        if (tx_ready) begin
          rd_fire = 1'b1;
          if (rd_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- queue bookkeeping and statistics ----------------
  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      wr_ptr_d[i]  = wr_ptr_q[i];
      start_d[i]   = start_q[i];
      rd_ptr_d[i]  = rd_ptr_q[i];
      cnt_d[i]     = cnt_q[i];
      pkt_cnt_d[i] = pkt_cnt_q[i];
      if (wq == QW'(i)) begin
        if (wr_en) begin
          wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
          cnt_d[i]    = cnt_d[i] + CW'(1);
          if (commit) begin
            start_d[i]   = wr_ptr_q[i] + PW'(1);
            pkt_cnt_d[i] = pkt_cnt_d[i] + CW'(1);
          end
        end
        if (rewind) begin
          wr_ptr_d[i] = start_q[i];
          cnt_d[i]    = cnt_d[i] - pkt_beats_q;
        end
      end
      if (rd_fire && sel_q == QW'(i)) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
        cnt_d[i]    = cnt_d[i] - CW'(1);
        if (rd_last) pkt_cnt_d[i] = pkt_cnt_d[i] - CW'(1);
      end
      q_full[i]  = (cnt_q[i] == CW'(Q_DEPTH));
      q_empty[i] = (cnt_q[i] == '0);
    end
    rx_pkt_d   = rx_pkt_q   + (commit              ? 32'd1 : 32'd0);
    tx_pkt_d   = tx_pkt_q   + ((rd_fire && rd_last) ? 32'd1 : 32'd0);
    drop_cnt_d = drop_cnt_q + (drop_evt            ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_Q; i++) begin
        wr_ptr_q[i]  <= '0;
        start_q[i]   <= '0;
        rd_ptr_q[i]  <= '0;
        cnt_q[i]     <= '0;
        pkt_cnt_q[i] <= '0;
      end
      in_pkt_q    <= 1'b0;
      cur_qid_q   <= '0;
      drop_q      <= 1'b0;
      pkt_beats_q <= '0;
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      rr_q        <= '0;
      rx_pkt_q    <= '0;
      tx_pkt_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_Q; i++) begin
        wr_ptr_q[i]  <= wr_ptr_d[i];
        start_q[i]   <= start_d[i];
        rd_ptr_q[i]  <= rd_ptr_d[i];
        cnt_q[i]     <= cnt_d[i];
        pkt_cnt_q[i] <= pkt_cnt_d[i];
      end
      in_pkt_q    <= in_pkt_d;
      cur_qid_q   <= cur_qid_d;
      drop_q      <= drop_d;
      pkt_beats_q <= pkt_beats_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_q        <= rr_d;
      rx_pkt_q    <= rx_pkt_d;
      tx_pkt_q    <= tx_pkt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign rx_pkt_cnt   = rx_pkt_q;
  assign tx_pkt_cnt   = tx_pkt_q;
  assign drop_pkt_cnt = drop_cnt_q;

`ifdef MQPC_BYTE_STATS_EN
  // Ingress bytes accumulate per packet and are credited on commit, so beats
  // of a packet that is later dropped never reach rx_byte_cnt.
  logic [31:0] pkt_bytes_q, pkt_bytes_d;
  logic [31:0] rx_bytes_q, rx_bytes_d, tx_bytes_q, tx_bytes_d;

  always_comb begin
    pkt_bytes_d = pkt_bytes_q;
    rx_bytes_d  = rx_bytes_q;
    tx_bytes_d  = tx_bytes_q;
    if (wr_en) begin
      if (commit) begin
        rx_bytes_d  = rx_bytes_q + pkt_bytes_q + 32'($countones(rx_keep));
        pkt_bytes_d = '0;
      end else begin
        pkt_bytes_d = pkt_bytes_q + 32'($countones(rx_keep));
      end
    end else if (acc) begin
      pkt_bytes_d = '0;
    end
    if (rd_fire) tx_bytes_d = tx_bytes_q + 32'($countones(tx_keep));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_bytes_q <= '0;
      rx_bytes_q  <= '0;
      tx_bytes_q  <= '0;
    end else begin
      pkt_bytes_q <= pkt_bytes_d;
      rx_bytes_q  <= rx_bytes_d;
      tx_bytes_q  <= tx_bytes_d;
    end
  end

  assign rx_byte_cnt = rx_bytes_q;
  assign tx_byte_cnt = tx_bytes_q;
`else
  assign rx_byte_cnt = '0;
  assign tx_byte_cnt = '0;
`endif

endmodule

// File: tb/tb_mq_port_controller.sv
// Directed bench for mq_port_controller (NUM_Q=4, Q_DEPTH=16, DATA_W=64).
// Beats carry {qid, packet id, beat index} in the low 24 data bits so each
// egress beat can be matched against a hand-written expectation.
module tb_mq_port_controller;
  localparam int DATA_W  = 64;
  localparam int NUM_Q   = 4;
  localparam int Q_DEPTH = 16;
  localparam int KEEP_W  = 8;
  localparam int QW      = 2;
`ifdef MQPC_BYTE_STATS_EN
  localparam bit BS = 1'b1;
`else
  localparam bit BS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              enable, rx_valid, rx_last, rx_ready;
  logic [DATA_W-1:0] rx_data, tx_data;
  logic [KEEP_W-1:0] rx_keep, tx_keep;
  logic [QW-1:0]     rx_qid, tx_qid;
  logic              tx_valid, tx_last, tx_ready, sched_mode;
  logic [NUM_Q-1:0]  q_full, q_empty;
  logic [31:0]       rx_pkt_cnt, tx_pkt_cnt, drop_pkt_cnt, rx_byte_cnt, tx_byte_cnt;
  logic [1:0]        dbg_state;

  mq_port_controller #(.DATA_W(DATA_W), .NUM_Q(NUM_Q), .Q_DEPTH(Q_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .rx_valid(rx_valid), .rx_last(rx_last), .rx_data(rx_data), .rx_keep(rx_keep),
    .rx_qid(rx_qid), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_data(tx_data), .tx_keep(tx_keep),
    .tx_qid(tx_qid), .tx_ready(tx_ready), .sched_mode(sched_mode),
    .q_full(q_full), .q_empty(q_empty),
    .rx_pkt_cnt(rx_pkt_cnt), .tx_pkt_cnt(tx_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt),
    .rx_byte_cnt(rx_byte_cnt), .tx_byte_cnt(tx_byte_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int vecs = 0;
  int errs = 0;
  logic [31:0] got_q[$];   // accepted egress beats, in order
  int rd_idx = 0;
  int valid_cycles = 0;

  // Sampled mid-cycle; a beat seen here with tx_ready=1 is accepted at the
  // following rising edge.
  always @(negedge clk) begin
    if (rst_n && tx_valid) begin
      valid_cycles++;
      if (tx_ready) got_q.push_back({4'(tx_qid), 3'b0, tx_last, tx_data[23:0]});
    end
  end

  function automatic logic [31:0] bw(input int q, input int pid, input int b, input bit last);
    return {4'(q), 3'b0, last, 8'(q), 8'(pid), 8'(b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_beat(input string tag, input logic [31:0] exp);
    logic [63:0] obs;
    obs = '1;
    if (rd_idx < got_q.size()) begin
      obs = 64'(got_q[rd_idx]);
      rd_idx++;
    end
    chk(tag, obs, 64'(exp));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int q, input int pid, input int n, input logic [7:0] keep);
    for (int b = 0; b < n; b++) begin
      rx_valid = 1'b1;
      // qid only matters on the first beat; later beats carry a decoy
      rx_qid   = (b == 0) ? QW'(q) : ~QW'(q);
      rx_data  = 64'({8'(q), 8'(pid), 8'(b)});
      rx_keep  = keep;
      rx_last  = (b == n - 1);
      tick();
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(tx_valid), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] snap;
    bit stall;
    int base_v, base_q;
    int ord_q[4];
    int ord_p[4];

    rst_n = 1'b0; enable = 1'b0; rx_valid = 1'b0; rx_last = 1'b0;
    rx_data = '0; rx_keep = '0; rx_qid = '0; tx_ready = 1'b0; sched_mode = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_last",  64'(tx_last),  64'd0);
    chk("rst_tx_qid",   64'(tx_qid),   64'd0);
    chk("rst_q_empty",  64'(q_empty),  64'hF);
    chk("rst_q_full",   64'(q_full),   64'h0);
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_rx_pkt",   64'(rx_pkt_cnt),   64'd0);
    chk("rst_drop",     64'(drop_pkt_cnt), 64'd0);
    chk("rst_state",    64'(dbg_state),    64'd0);

    rst_n = 1'b1; enable = 1'b1;
    tick();
    chk("rx_ready_en", 64'(rx_ready), 64'd1);

    // Single 3-beat packet to queue 2, two-cycle latency
    tx_ready = 1'b1;
    send_pkt(2, 1, 3, 8'hFF);
    chk("lat_c1_valid", 64'(tx_valid),  64'd0);
    chk("lat_c1_state", 64'(dbg_state), 64'd1);
    tick();
    chk("lat_c2_valid", 64'(tx_valid), 64'd1);
    chk("lat_c2_qid",   64'(tx_qid),   64'd2);
    repeat (3) tick();
    next_beat("t1_b0", bw(2, 1, 0, 1'b0));
    next_beat("t1_b1", bw(2, 1, 1, 1'b0));
    next_beat("t1_b2", bw(2, 1, 2, 1'b1));
    chk("t1_rx_pkt",   64'(rx_pkt_cnt),  64'd1);
    chk("t1_tx_pkt",   64'(tx_pkt_cnt),  64'd1);
    chk("t1_rx_bytes", 64'(rx_byte_cnt), BS ? 64'd24 : 64'd0);
    chk("t1_tx_bytes", 64'(tx_byte_cnt), BS ? 64'd24 : 64'd0);

    // Overflow: 17 single-beat packets into a 16-deep queue with egress stalled
    tx_ready = 1'b0;
    for (int p = 0; p < 17; p++) send_pkt(0, p, 1, 8'hFF);
    chk("t2_q_full", 64'(q_full),       64'h1);
    chk("t2_drop",   64'(drop_pkt_cnt), 64'd1);
    chk("t2_rx_pkt", 64'(rx_pkt_cnt),   64'd17);
    chk("t2_held",   64'(tx_valid),     64'd1);
    tx_ready = 1'b1;
    repeat (60) tick();
    for (int p = 0; p < 16; p++) next_beat("t2_beat", bw(0, p, 0, 1'b1));
    chk("t2_extra",   64'(got_q.size() - rd_idx), 64'd0);
    chk("t2_tx_pkt",  64'(tx_pkt_cnt), 64'd17);
    chk("t2_q_empty", 64'(q_empty),    64'hF);

    // Mid-packet overflow: 20 beats into an empty 16-deep queue
    base_v = valid_cycles;
    send_pkt(1, 'h20, 20, 8'hFF);
    repeat (5) tick();
    chk("t3_drop",    64'(drop_pkt_cnt), 64'd2);
    chk("t3_q_empty", 64'(q_empty),      64'hF);
    chk("t3_rx_pkt",  64'(rx_pkt_cnt),   64'd17);
    chk("t3_no_tx",   64'(valid_cycles - base_v), 64'd0);

    // Strict priority: queues 0 and 3 each hold two 2-beat packets
    ord_p[0] = 'h10; ord_p[1] = 'h11; ord_p[2] = 'h30; ord_p[3] = 'h31;
    ord_q[0] = 0;    ord_q[1] = 0;    ord_q[2] = 3;    ord_q[3] = 3;
    sched_mode = 1'b0; tx_ready = 1'b0;
    send_pkt(0, 'h10, 2, 8'hFF);
    send_pkt(3, 'h30, 2, 8'hFF);
    send_pkt(0, 'h11, 2, 8'hFF);
    send_pkt(3, 'h31, 2, 8'hFF);
    tx_ready = 1'b1;
    repeat (30) tick();
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 2; b++)
        next_beat("strict_beat", bw(ord_q[k], ord_p[k], b, b == 1));

    // Round-robin: same load, order alternates 0,3,0,3
    ord_p[0] = 'h10; ord_p[1] = 'h30; ord_p[2] = 'h11; ord_p[3] = 'h31;
    ord_q[0] = 0;    ord_q[1] = 3;    ord_q[2] = 0;    ord_q[3] = 3;
    sched_mode = 1'b1; tx_ready = 1'b0;
    send_pkt(0, 'h10, 2, 8'hFF);
    send_pkt(3, 'h30, 2, 8'hFF);
    send_pkt(0, 'h11, 2, 8'hFF);
    send_pkt(3, 'h31, 2, 8'hFF);
    tx_ready = 1'b1;
    repeat (30) tick();
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 2; b++)
        next_beat("rr_beat", bw(ord_q[k], ord_p[k], b, b == 1));
    chk("t4_rx_pkt", 64'(rx_pkt_cnt), 64'd25);
    chk("t4_tx_pkt", 64'(tx_pkt_cnt), 64'd25);

    // Backpressure: tx_ready toggles every cycle, outputs hold while stalled
    sched_mode = 1'b0; tx_ready = 1'b0;
    send_pkt(1, 'h40, 4, 8'h0F);
    wait_valid("t5_wait");
    for (int i = 0; i < 10; i++) begin
      snap  = {tx_valid, tx_last, tx_qid, tx_keep, tx_data[51:0]};
      stall = tx_valid && !tx_ready;
      tick();
      if (stall) chk("t5_hold", {tx_valid, tx_last, tx_qid, tx_keep, tx_data[51:0]}, snap);
      tx_ready = !tx_ready;
    end
    repeat (5) tick();
    for (int b = 0; b < 4; b++) next_beat("t5_beat", bw(1, 'h40, b, b == 3));
    chk("t5_rx_pkt",   64'(rx_pkt_cnt),  64'd26);
    chk("t5_tx_pkt",   64'(tx_pkt_cnt),  64'd26);
    chk("t5_rx_bytes", 64'(rx_byte_cnt), BS ? 64'd296 : 64'd0);
    chk("t5_tx_bytes", 64'(tx_byte_cnt), BS ? 64'd296 : 64'd0);

    // Reset mid-SEND
    tx_ready = 1'b0;
    send_pkt(2, 'h50, 3, 8'hFF);
    wait_valid("t6_wait");
    rst_n = 1'b0;
    #1;
    chk("t6_tx_valid", 64'(tx_valid),     64'd0);
    chk("t6_tx_last",  64'(tx_last),      64'd0);
    chk("t6_tx_qid",   64'(tx_qid),       64'd0);
    chk("t6_rx_pkt",   64'(rx_pkt_cnt),   64'd0);
    chk("t6_tx_pkt",   64'(tx_pkt_cnt),   64'd0);
    chk("t6_drop",     64'(drop_pkt_cnt), 64'd0);
    chk("t6_rx_bytes", 64'(rx_byte_cnt),  64'd0);
    chk("t6_tx_bytes", 64'(tx_byte_cnt),  64'd0);
    chk("t6_q_empty",  64'(q_empty),      64'hF);
    chk("t6_q_full",   64'(q_full),       64'h0);
    chk("t6_rx_ready", 64'(rx_ready),     64'd0);
    repeat (2) tick();
    rst_n = 1'b1; tx_ready = 1'b1;
    base_v = valid_cycles;
    base_q = got_q.size();
    repeat (10) tick();
    chk("t6_no_stale_valid", 64'(valid_cycles - base_v), 64'd0);
    chk("t6_no_stale_beat",  64'(got_q.size() - base_q), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
